// File: rtl/serdes_link_pkg.sv
// Types and constants shared by the serdes transmit framer and receive deframer.
// The default nibble values define the line protocol seen by both ends.
package serdes_link_pkg;

   typedef enum logic [2:0] {
      WAIT_GEAR,
      TRAIN,
      IDLE,
      SOF,
      DATA,
      CHK
   } link_state_e;

   localparam logic [3:0] DEF_TRAIN_NIBBLE = 4'h3;
   localparam logic [3:0] DEF_SOF_NIBBLE   = 4'hA;
   localparam logic [3:0] DEF_IDLE_NIBBLE  = 4'h0;

   function automatic logic [3:0] nib_xor(input logic [3:0] acc, input logic [3:0] nib);
      return acc ^ nib;
   endfunction

endpackage

// File: rtl/serdes_tx_framer.sv
// Frames payload words as SOF, NIB data nibbles (MSB first) and an XOR check
// nibble for the x2 ODDR gearbox, preceded by a training burst for word alignment.
module serdes_tx_framer
   import serdes_link_pkg::*;
#(
   parameter int         DATA_W       = 16,
   parameter int         TRAIN_LEN    = 64,
   parameter logic [3:0] TRAIN_NIBBLE = DEF_TRAIN_NIBBLE,
   parameter logic [3:0] SOF_NIBBLE   = DEF_SOF_NIBBLE,
   parameter logic [3:0] IDLE_NIBBLE  = DEF_IDLE_NIBBLE
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              gear_ready,
   input  logic              retrain,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [3:0]        oddr_q,
   output logic              link_up,
   output logic              frame_abort
);

   localparam int NIB = DATA_W / 4;
   localparam int TCW = $clog2(TRAIN_LEN + 1);
   localparam int NCW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_LEN - 1);
   localparam logic [NCW-1:0] NIB_LAST   = NCW'(NIB - 1);

   link_state_e       r_state;
   logic [3:0]        r_oddr_q;
   logic              r_link_up;
   logic              r_frame_abort;
   logic [DATA_W-1:0] r_shift;
   logic [3:0]        r_xor;
   logic [TCW-1:0]    r_train_cnt;
   logic [NCW-1:0]    r_nib_cnt;
   logic              r_pend;

   logic w_last_nib;
   logic w_tx_ready;
   logic w_xfer;
   logic w_in_frame;

   // A word can be taken while idle or on the last data nibble so the next SOF follows CHK directly.
   assign w_last_nib = (r_state == DATA) && (r_nib_cnt == NIB_LAST);
   assign w_tx_ready = ((r_state == IDLE) || w_last_nib) && gear_ready && !retrain;
   assign w_xfer     = tx_valid && w_tx_ready;
   assign w_in_frame = (r_state == SOF) || (r_state == DATA) || (r_state == CHK);

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= WAIT_GEAR;
         r_oddr_q      <= 4'h0;
         r_link_up     <= 1'b0;
         r_frame_abort <= 1'b0;
         r_shift       <= '0;
         r_xor         <= 4'h0;
         r_train_cnt   <= '0;
         r_nib_cnt     <= '0;
         r_pend        <= 1'b0;
      end else begin
         r_frame_abort <= 1'b0;
         if (!gear_ready && (r_state != WAIT_GEAR)) begin
            r_state       <= WAIT_GEAR;
            r_oddr_q      <= IDLE_NIBBLE;
            r_link_up     <= 1'b0;
            r_frame_abort <= w_in_frame;
            r_pend        <= 1'b0;
            r_train_cnt   <= '0;
            r_nib_cnt     <= '0;
         end else begin
            case (r_state)
               WAIT_GEAR: begin
                  r_oddr_q <= IDLE_NIBBLE;
                  if (gear_ready) begin
                     r_state     <= TRAIN;
                     r_train_cnt <= '0;
                  end
               end
               TRAIN: begin
                  r_oddr_q <= TRAIN_NIBBLE;
                  if (r_train_cnt == TRAIN_LAST) begin
                     r_state     <= IDLE;
                     r_link_up   <= 1'b1;
                     r_train_cnt <= '0;
                  end else begin
                     r_train_cnt <= r_train_cnt + TCW'(1);
                  end
               end
               IDLE: begin
                  r_oddr_q <= IDLE_NIBBLE;
                  if (retrain) begin
                     r_state     <= TRAIN;
                     r_link_up   <= 1'b0;
                     r_train_cnt <= '0;
                  end else if (w_xfer) begin
                     r_shift <= tx_data;
                     r_state <= SOF;
                  end
               end
               SOF: begin
                  r_oddr_q  <= SOF_NIBBLE;
                  r_xor     <= 4'h0;
                  r_nib_cnt <= '0;
                  r_state   <= DATA;
               end
               DATA: begin
                  r_oddr_q <= r_shift[DATA_W-1 -: 4];
                  r_xor    <= nib_xor(r_xor, r_shift[DATA_W-1 -: 4]);
                  r_shift  <= r_shift << 4;
                  // The next word lands in the shift register as its last old nibble leaves.
                  if (w_xfer) begin
                     r_shift <= tx_data;
                     r_pend  <= 1'b1;
                  end
                  if (w_last_nib) begin
                     r_state   <= CHK;
                     r_nib_cnt <= '0;
                  end else begin
                     r_nib_cnt <= r_nib_cnt + NCW'(1);
                  end
               end
               CHK: begin
                  r_oddr_q <= r_xor;
                  r_pend   <= 1'b0;
                  if (r_pend) begin
                     r_state <= SOF;
                  end else if (retrain) begin
                     r_state     <= TRAIN;
                     r_link_up   <= 1'b0;
                     r_train_cnt <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end
               default: begin
                  r_state  <= WAIT_GEAR;
                  r_oddr_q <= IDLE_NIBBLE;
               end
            endcase
         end
      end
   end

   assign tx_ready    = w_tx_ready;
   assign oddr_q      = r_oddr_q;
   assign link_up     = r_link_up;
   assign frame_abort = r_frame_abort;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Directed bench for serdes_tx_framer: vector table for framing and handshake,
// hand-written sequences for training, gear loss, retrain collisions and reset.
module tb_serdes_tx_framer;

   typedef struct {
      logic        gear;
      logic        retrain;
      logic        valid;
      logic [15:0] data;
      logic        expReady;
      logic [3:0]  expQ;
      logic        expLink;
      logic        expAbort;
   } vec_t;

   logic        sclk;
   logic        rst_n;
   logic        gearReady;
   logic        retrain;
   logic [15:0] txData;
   logic        txValid;
   logic        txReady;
   logic [3:0]  oddrQ;
   logic        linkUp;
   logic        frameAbort;

   int checks;
   int failures;
   int stepNo;

   vec_t tbl[29];

   serdes_tx_framer #(.DATA_W(16), .TRAIN_LEN(64)) dut (
      .sclk        (sclk),
      .rst_n       (rst_n),
      .gear_ready  (gearReady),
      .retrain     (retrain),
      .tx_data     (txData),
      .tx_valid    (txValid),
      .tx_ready    (txReady),
      .oddr_q      (oddrQ),
      .link_up     (linkUp),
      .frame_abort (frameAbort)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input logic g, input logic r, input logic v, input logic [15:0] d,
                               input logic er, input logic [3:0] eq, input logic el, input logic ea);
      vec_t x;
      x.gear = g; x.retrain = r; x.valid = v; x.data = d;
      x.expReady = er; x.expQ = eq; x.expLink = el; x.expAbort = ea;
      return x;
   endfunction

   task automatic checkOutput(input string what, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s step %0d: got %h required %h", what, stepNo, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check tx_ready before the edge and the registered outputs after it.
   task automatic applyStimulus(input vec_t v);
      stepNo++;
      gearReady = v.gear;
      retrain   = v.retrain;
      txValid   = v.valid;
      txData    = v.data;
      #1;
      checkOutput("tx_ready", {3'b000, txReady}, {3'b000, v.expReady});
      @(posedge sclk);
      #1;
      checkOutput("oddr_q", oddrQ, v.expQ);
      checkOutput("link_up", {3'b000, linkUp}, {3'b000, v.expLink});
      checkOutput("frame_abort", {3'b000, frameAbort}, {3'b000, v.expAbort});
   endtask

   task automatic trainBurst(input logic v, input logic [15:0] d);
      for (int i = 0; i < 64; i++)
         applyStimulus(mk(1'b1, 1'b0, v, d, 1'b0, 4'h3, (i == 63), 1'b0));
   endtask

   initial begin
      checks = 0; failures = 0; stepNo = 0;

      // Single word 0x1234
      tbl[0]  = mk(1, 0, 1, 16'h1234, 1, 4'h0, 1, 0);
      tbl[1]  = mk(1, 0, 0, 16'h0000, 0, 4'hA, 1, 0);
      tbl[2]  = mk(1, 0, 0, 16'h0000, 0, 4'h1, 1, 0);
      tbl[3]  = mk(1, 0, 0, 16'h0000, 0, 4'h2, 1, 0);
      tbl[4]  = mk(1, 0, 0, 16'h0000, 0, 4'h3, 1, 0);
      tbl[5]  = mk(1, 0, 0, 16'h0000, 1, 4'h4, 1, 0);
      tbl[6]  = mk(1, 0, 0, 16'h0000, 0, 4'h4, 1, 0);
      tbl[7]  = mk(1, 0, 0, 16'h0000, 1, 4'h0, 1, 0);
      // Back-to-back 0xFFFF then 0x0F0F
      tbl[8]  = mk(1, 0, 1, 16'hFFFF, 1, 4'h0, 1, 0);
      tbl[9]  = mk(1, 0, 1, 16'h0F0F, 0, 4'hA, 1, 0);
      tbl[10] = mk(1, 0, 1, 16'h0F0F, 0, 4'hF, 1, 0);
      tbl[11] = mk(1, 0, 1, 16'h0F0F, 0, 4'hF, 1, 0);
      tbl[12] = mk(1, 0, 1, 16'h0F0F, 0, 4'hF, 1, 0);
      tbl[13] = mk(1, 0, 1, 16'h0F0F, 1, 4'hF, 1, 0);
      tbl[14] = mk(1, 0, 0, 16'h0000, 0, 4'h0, 1, 0);
      tbl[15] = mk(1, 0, 0, 16'h0000, 0, 4'hA, 1, 0);
      tbl[16] = mk(1, 0, 0, 16'h0000, 0, 4'h0, 1, 0);
      tbl[17] = mk(1, 0, 0, 16'h0000, 0, 4'hF, 1, 0);
      tbl[18] = mk(1, 0, 0, 16'h0000, 0, 4'h0, 1, 0);
      tbl[19] = mk(1, 0, 0, 16'h0000, 1, 4'hF, 1, 0);
      tbl[20] = mk(1, 0, 0, 16'h0000, 0, 4'h0, 1, 0);
      tbl[21] = mk(1, 0, 0, 16'h0000, 1, 4'h0, 1, 0);
      // 0xBEEF with retrain raised mid-frame; check nibble B^E^E^F = 4
      tbl[22] = mk(1, 0, 1, 16'hBEEF, 1, 4'h0, 1, 0);
      tbl[23] = mk(1, 1, 0, 16'h0000, 0, 4'hA, 1, 0);
      tbl[24] = mk(1, 1, 0, 16'h0000, 0, 4'hB, 1, 0);
      tbl[25] = mk(1, 1, 0, 16'h0000, 0, 4'hE, 1, 0);
      tbl[26] = mk(1, 1, 0, 16'h0000, 0, 4'hE, 1, 0);
      tbl[27] = mk(1, 1, 0, 16'h0000, 0, 4'hF, 1, 0);
      tbl[28] = mk(1, 1, 0, 16'h0000, 0, 4'h4, 0, 0);

      rst_n = 1'b0; gearReady = 1'b1; retrain = 1'b0; txValid = 1'b0; txData = 16'h0000;
      repeat (3) @(posedge sclk);
      #1;
      checkOutput("reset oddr_q", oddrQ, 4'h0);
      checkOutput("reset tx_ready", {3'b000, txReady}, 4'h0);
      checkOutput("reset link_up", {3'b000, linkUp}, 4'h0);
      checkOutput("reset frame_abort", {3'b000, frameAbort}, 4'h0);
      rst_n = 1'b1;

      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'h0, 0, 0));
      trainBurst(1'b0, 16'h0000);

      for (int i = 0; i < 29; i++)
         applyStimulus(tbl[i]);

      trainBurst(1'b0, 16'h0000);
      applyStimulus(mk(1, 0, 0, 16'h0000, 1, 4'h0, 1, 0));

      $display("[TB] gear_ready loss on second data nibble");
      applyStimulus(mk(1, 0, 1, 16'h5678, 1, 4'h0, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'hA, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'h5, 1, 0));
      applyStimulus(mk(0, 0, 0, 16'h0000, 0, 4'h0, 0, 1));
      applyStimulus(mk(0, 0, 0, 16'h0000, 0, 4'h0, 0, 0));
      applyStimulus(mk(0, 0, 1, 16'h1111, 0, 4'h0, 0, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'h0, 0, 0));
      trainBurst(1'b0, 16'h0000);
      applyStimulus(mk(1, 0, 0, 16'h0000, 1, 4'h0, 1, 0));

      $display("[TB] tx_valid and retrain in the same idle cycle");
      applyStimulus(mk(1, 1, 1, 16'h9ABC, 0, 4'h0, 0, 0));
      trainBurst(1'b1, 16'h9ABC);
      applyStimulus(mk(1, 0, 1, 16'h9ABC, 1, 4'h0, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'hA, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'h9, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'hA, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'hB, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 1, 4'hC, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'h4, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 1, 4'h0, 1, 0));

      $display("[TB] asynchronous reset mid-frame");
      applyStimulus(mk(1, 0, 1, 16'h1357, 1, 4'h0, 1, 0));
      applyStimulus(mk(1, 0, 0, 16'h0000, 0, 4'hA, 1, 0));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset oddr_q", oddrQ, 4'h0);
      checkOutput("async reset link_up", {3'b000, linkUp}, 4'h0);
      checkOutput("async reset tx_ready", {3'b000, txReady}, 4'h0);
      @(posedge sclk);
      #1;
      checkOutput("async reset frame_abort", {3'b000, frameAbort}, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
